// File: rtl/fpu_issue_scheduler_pkg.sv
// FPU issue scheduler shared types: op codes, unit codes,
// op-to-unit steering and the packed result width.
package fpu_issue_scheduler_pkg;

  localparam int FPU_RES_W   = 40;
  localparam int FPU_N_UNITS = 4;

  localparam logic [4:0] FPU_OP_ADD   = 5'd0;
  localparam logic [4:0] FPU_OP_SUB   = 5'd1;
  localparam logic [4:0] FPU_OP_MUL   = 5'd2;
  localparam logic [4:0] FPU_OP_DIV   = 5'd3;
  localparam logic [4:0] FPU_OP_SQRT  = 5'd4;
  localparam logic [4:0] FPU_OP_MIN   = 5'd5;
  localparam logic [4:0] FPU_OP_MAX   = 5'd6;
  localparam logic [4:0] FPU_OP_FMADD = 5'd7;

  typedef enum logic [1:0] {
    UNIT_ADD,
    UNIT_MUL,
    UNIT_DIV,
    UNIT_SQRT
  } fpu_unit_t;

  // Unlisted ops (compares, conversions) run on the adder.
  function automatic fpu_unit_t fpu_unit_of(
    input logic [4:0] op
  );
    fpu_unit_of = UNIT_ADD;
    case (op)
      FPU_OP_MUL,
      FPU_OP_FMADD: fpu_unit_of = UNIT_MUL;
      FPU_OP_DIV:   fpu_unit_of = UNIT_DIV;
      FPU_OP_SQRT:  fpu_unit_of = UNIT_SQRT;
      default:      fpu_unit_of = UNIT_ADD;
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_scheduler_if.sv
// Decode, functional-unit and writeback handshakes of the
// FPU issue scheduler; slave = scheduler, master = pipeline.
interface fpu_issue_scheduler_if #(
  parameter int N_UNITS = 4,
  parameter int RES_W   = 40
);
  logic                     valid_in;
  logic                     ready_out;
  logic [4:0]               op;
  logic [N_UNITS-1:0]       unit_valid;
  logic [N_UNITS-1:0]       unit_ready;
  logic [N_UNITS-1:0]       unit_valid_out;
  logic [N_UNITS-1:0]       unit_ready_in;
  logic [N_UNITS*RES_W-1:0] unit_res;
  logic                     valid_out;
  logic                     ready_in;
  logic [RES_W-1:0]         res_out;
  logic                     busy;

  modport slave (
    input  valid_in, op, unit_ready,
    input  unit_valid_out, unit_res,
    input  ready_in,
    output ready_out, unit_valid,
    output unit_ready_in, valid_out,
    output res_out, busy
  );

  modport master (
    output valid_in, op, unit_ready,
    output unit_valid_out, unit_res,
    output ready_in,
    input  ready_out, unit_valid,
    input  unit_ready_in, valid_out,
    input  res_out, busy
  );
endinterface

// File: rtl/fpu_issue_scheduler_order_fifo.sv
// Program-order FIFO of unit codes for in-flight FPU ops;
// the head names the unit whose result retires next.
module fpu_order_fifo
  import fpu_issue_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  fpu_unit_t din,
  output fpu_unit_t head,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fpu_unit_t      mem_q [DEPTH];
  fpu_unit_t      mem_d [DEPTH];
  logic [PW-1:0]  wr_q, wr_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= UNIT_ADD;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/fpu_issue_scheduler.sv
// FPU issue scheduler: steers ops to units, retires results
// in program order and guards unit results from overwrite.
module fpu_issue_scheduler
  import fpu_issue_scheduler_pkg::*;
#(
  parameter int N_UNITS = FPU_N_UNITS,
  parameter int DEPTH   = 4,
  parameter int RES_W   = FPU_RES_W
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  fpu_issue_scheduler_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);

  fpu_unit_t     u;
  fpu_unit_t     head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          kill;
  logic [CW-1:0] out_cnt_q [N_UNITS];
  logic [CW-1:0] out_cnt_d [N_UNITS];

  assign kill = flush || reset;
  assign u    = fpu_unit_of(bus.op);

  fpu_order_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (u),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    bus.unit_valid    = '0;
    bus.unit_valid[u] = bus.valid_in && !full && !kill;
    bus.ready_out     = bus.unit_ready[u] && !full && !kill;
    bus.valid_out     = !empty && !kill
                     && bus.unit_valid_out[head];
    bus.res_out       = '0;
    if (!empty)
      bus.res_out = bus.unit_res[int'(head)*RES_W +: RES_W];
    push = bus.valid_in && bus.ready_out;
    pop  = bus.valid_out && bus.ready_in;
    // A busy unit may only take a new op as its result leaves.
    for (int i = 0; i < N_UNITS; i++) begin
      bus.unit_ready_in[i] = (out_cnt_q[i] == '0)
        || (!empty && int'(head) == i && bus.ready_in);
      out_cnt_d[i] = out_cnt_q[i]
        + CW'(push && int'(u) == i)
        - CW'(pop && int'(head) == i);
      if (flush) out_cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_UNITS; i++)
        out_cnt_q[i] <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.busy = !empty;

endmodule
